// File: rtl/edf_irq_gateway.sv
// ---------------------------------------------------------------------------
// edf_irq_gateway
//
// Front end of the EDF interrupt controller. Raw interrupt lines are
// (optionally) synchronised, turned into edge- or level-triggered events,
// and latched as per-line pending bits. Every accepted event stamps an
// absolute deadline = current timebase + the line's relative deadline, so
// the arbitration stage downstream can pick the most urgent pending line.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   irq_i          raw interrupt lines, one bit per line
//   cfg_we_i       configuration write strobe
//   cfg_idx_i      line addressed by the configuration write
//   cfg_en_i       line enable written by cfg_we_i
//   cfg_level_i    trigger mode written by cfg_we_i (1 = level, 0 = edge)
//   cfg_rel_dl_i   relative deadline written by cfg_we_i
//   claim_valid_i  claim strobe from the arbitration stage
//   claim_id_i     line being claimed
//   time_o         free-running timebase
//   pend_o         pending bit per line
//   abs_dl_o       absolute deadline per line, line i at [i*TimeWidth +: TimeWidth]
//   lost_o         sticky: an edge event hit a line that was already pending
// ---------------------------------------------------------------------------
module edf_irq_gateway #(
  parameter int NrIrqs     = 32,
  parameter bit IsAsync    = 1'b1,
  parameter int SyncStages = 2,
  parameter int TimeWidth  = 16,
  parameter int IrqIdWidth = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NrIrqs-1:0]           irq_i,
  input  logic                        cfg_we_i,
  input  logic [IrqIdWidth-1:0]       cfg_idx_i,
  input  logic                        cfg_en_i,
  input  logic                        cfg_level_i,
  input  logic [TimeWidth-1:0]        cfg_rel_dl_i,
  input  logic                        claim_valid_i,
  input  logic [IrqIdWidth-1:0]       claim_id_i,
  output logic [TimeWidth-1:0]        time_o,
  output logic [NrIrqs-1:0]           pend_o,
  output logic [NrIrqs*TimeWidth-1:0] abs_dl_o,
  output logic [NrIrqs-1:0]           lost_o
);

  logic [TimeWidth-1:0] time_q;
  logic [NrIrqs-1:0]    s_line;
  logic [NrIrqs-1:0]    d_q;
  logic [NrIrqs-1:0]    en_q;
  logic [NrIrqs-1:0]    level_q;
  logic [NrIrqs-1:0]    pend_q;
  logic [NrIrqs-1:0]    lost_q;
  logic [TimeWidth-1:0] rel_dl_q [NrIrqs];
  logic [TimeWidth-1:0] abs_dl_q [NrIrqs];

  logic [NrIrqs-1:0]    ev;
  logic [NrIrqs-1:0]    claim_hit;
  logic [NrIrqs-1:0]    cfg_hit;

  // Synchroniser chain for asynchronous sources. The whole chain is cleared
  // by reset so a sample in flight when reset hits can never show up as a
  // late event afterwards. Synchronous sources bypass the chain entirely.
  if (IsAsync) begin : g_sync
    logic [NrIrqs-1:0] sync_q [SyncStages];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= irq_i;
        for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s_line = sync_q[SyncStages-1];
  end else begin : g_nosync
    assign s_line = irq_i;
  end

  // Decode claims and config writes into one-hot per-line strobes and form
  // the per-line event. Out-of-range indices simply match no line. Level
  // lines only raise an event while not pending, so holding a level line
  // high re-pends it right after a claim instead of flagging lost events.
  always_comb begin
    ev        = '0;
    claim_hit = '0;
    cfg_hit   = '0;
    for (int i = 0; i < NrIrqs; i++) begin
      claim_hit[i] = claim_valid_i && (claim_id_i == IrqIdWidth'(i));
      cfg_hit[i]   = cfg_we_i && (cfg_idx_i == IrqIdWidth'(i));
      ev[i]        = en_q[i] & s_line[i] & (level_q[i] ? ~pend_q[i] : ~d_q[i]);
    end
  end

  // Timebase, edge-delay flops, configuration and per-line pending state.
  // Priority per line, lowest to highest: claim clears pend; an event (which
  // also wins over a same-cycle claim) sets pend and re-stamps the deadline;
  // an edge event on a pending, unclaimed line only marks it lost; finally a
  // config write clears lost, and a disabling write also drops pend. Events
  // are judged against the configuration held before a same-cycle write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      time_q  <= '0;
      d_q     <= '0;
      en_q    <= '0;
      level_q <= '0;
      pend_q  <= '0;
      lost_q  <= '0;
      for (int i = 0; i < NrIrqs; i++) begin
        rel_dl_q[i] <= '0;
        abs_dl_q[i] <= '0;
      end
    end else begin
      time_q <= time_q + TimeWidth'(1);
      d_q    <= s_line;
      for (int i = 0; i < NrIrqs; i++) begin
        if (cfg_hit[i]) begin
          en_q[i]     <= cfg_en_i;
          level_q[i]  <= cfg_level_i;
          rel_dl_q[i] <= cfg_rel_dl_i;
        end

        if (ev[i] && (!pend_q[i] || claim_hit[i])) begin
          pend_q[i]   <= 1'b1;
          abs_dl_q[i] <= time_q + rel_dl_q[i];
        end else if (ev[i]) begin
          lost_q[i] <= 1'b1;
        end else if (claim_hit[i]) begin
          pend_q[i] <= 1'b0;
        end

        if (cfg_hit[i]) begin
          lost_q[i] <= 1'b0;
          if (!cfg_en_i) pend_q[i] <= 1'b0;
        end
      end
    end
  end

  // Flatten the per-line deadlines onto the output bus.
  always_comb begin
    abs_dl_o = '0;
    for (int i = 0; i < NrIrqs; i++) begin
      abs_dl_o[i*TimeWidth +: TimeWidth] = abs_dl_q[i];
    end
  end

  assign time_o = time_q;
  assign pend_o = pend_q;
  assign lost_o = lost_q;

endmodule

// File: tb/tb_edf_irq_gateway.sv
// ---------------------------------------------------------------------------
// tb_edf_irq_gateway
//
// Directed bench for edf_irq_gateway. The stimulus thread drives inputs just
// after rising edges and, for each step, queues the values the outputs must
// show after a given edge count. A separate monitor samples the outputs on
// every falling edge and retires whatever expectations fall due then.
//
// Timeline: reset is held for edges 1..3, so after edge n the timebase reads
// (n - 3) mod 2**16, and an event seen in the cycle after edge n stamps with
// that value. With a 2-stage synchroniser, a line driven high just after
// edge k is pending after edge k+3.
// ---------------------------------------------------------------------------
module tb_edf_irq_gateway;

  localparam int NrIrqs     = 32;
  localparam int TimeWidth  = 16;
  localparam int IrqIdWidth = 8;

  localparam int KTime = 0;
  localparam int KPend = 1;
  localparam int KAbs  = 2;
  localparam int KLost = 3;

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic [NrIrqs-1:0]           irq_i;
  logic                        cfg_we_i;
  logic [IrqIdWidth-1:0]       cfg_idx_i;
  logic                        cfg_en_i;
  logic                        cfg_level_i;
  logic [TimeWidth-1:0]        cfg_rel_dl_i;
  logic                        claim_valid_i;
  logic [IrqIdWidth-1:0]       claim_id_i;
  logic [TimeWidth-1:0]        time_o;
  logic [NrIrqs-1:0]           pend_o;
  logic [NrIrqs*TimeWidth-1:0] abs_dl_o;
  logic [NrIrqs-1:0]           lost_o;

  typedef struct {
    int          at_cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  edf_irq_gateway #(
    .NrIrqs(NrIrqs), .IsAsync(1'b1), .SyncStages(2),
    .TimeWidth(TimeWidth), .IrqIdWidth(IrqIdWidth)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_en_i(cfg_en_i),
    .cfg_level_i(cfg_level_i), .cfg_rel_dl_i(cfg_rel_dl_i),
    .claim_valid_i(claim_valid_i), .claim_id_i(claim_id_i),
    .time_o(time_o), .pend_o(pend_o), .abs_dl_o(abs_dl_o), .lost_o(lost_o)
  );

  // Free-running clock and edge counter used to schedule everything.
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Compare one sampled value against its required value and log a failure.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cyc %0d: got 0x%0h, required 0x%0h",
               name, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] read_dut(input int kind, input int idx);
    case (kind)
      KTime:   return {16'h0, time_o};
      KPend:   return pend_o;
      KAbs:    return {16'h0, abs_dl_o[idx*TimeWidth +: TimeWidth]};
      default: return lost_o;
    endcase
  endfunction

  // Queue an expectation to be checked after edge number 'at'.
  task automatic push_exp(input int at, input int kind, input int idx,
                          input logic [31:0] val, input string name);
    exp_t e;
    e.at_cyc = at;
    e.kind   = kind;
    e.idx    = idx;
    e.val    = val;
    e.name   = name;
    sb.push_back(e);
  endtask

  // Monitor: on every falling edge retire the expectations due now; any
  // expectation whose cycle has already passed counts as a failure.
  always @(negedge clk_i) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at_cyc == cyc) begin
        checkOutput(sb[i].name, read_dut(sb[i].kind, sb[i].idx), sb[i].val);
        sb.delete(i);
      end else if (sb[i].at_cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: expectation for cyc %0d missed, required 0x%0h",
                 sb[i].name, sb[i].at_cyc, sb[i].val);
        sb.delete(i);
      end
    end
  end

  // Advance to just after edge n (no-op if already there).
  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Drive one interrupt line to a level just after edge n.
  task automatic applyStimulus(input int n, input int line, input logic v);
    at_edge(n);
    irq_i[line] = v;
  endtask

  // One-cycle config write presented after edge n, taking effect at edge n+1.
  task automatic cfg_write(input int n, input int idx, input logic en,
                           input logic lvl, input logic [TimeWidth-1:0] rel);
    at_edge(n);
    cfg_we_i     = 1'b1;
    cfg_idx_i    = IrqIdWidth'(idx);
    cfg_en_i     = en;
    cfg_level_i  = lvl;
    cfg_rel_dl_i = rel;
    at_edge(n + 1);
    cfg_we_i = 1'b0;
  endtask

  // One-cycle claim presented after edge n, taking effect at edge n+1.
  task automatic claim(input int n, input int id);
    at_edge(n);
    claim_valid_i = 1'b1;
    claim_id_i    = IrqIdWidth'(id);
    at_edge(n + 1);
    claim_valid_i = 1'b0;
  endtask

  // Safety net so the bench always ends even if scheduling goes wrong.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    rst_i         = 1'b1;
    irq_i         = '0;
    cfg_we_i      = 1'b0;
    cfg_idx_i     = '0;
    cfg_en_i      = 1'b0;
    cfg_level_i   = 1'b0;
    cfg_rel_dl_i  = '0;
    claim_valid_i = 1'b0;
    claim_id_i    = '0;

    // Reset state and first timebase tick.
    push_exp(3, KTime, 0, 32'h0, "rst_time");
    push_exp(3, KPend, 0, 32'h0, "rst_pend");
    push_exp(3, KLost, 0, 32'h0, "rst_lost");
    push_exp(3, KAbs,  3, 32'h0, "rst_abs3");
    push_exp(4, KTime, 0, 32'h1, "time_first_tick");

    at_edge(3);
    rst_i = 1'b0;
    cfg_write(3, 3, 1'b1, 1'b0, 16'd100);
    cfg_write(4, 5, 1'b1, 1'b1, 16'd10);
    cfg_write(5, 7, 1'b1, 1'b0, 16'd20);
    cfg_write(6, 1, 1'b1, 1'b0, 16'd5);
    cfg_write(7, 2, 1'b1, 1'b0, 16'd5);
    cfg_write(8, 4, 1'b1, 1'b0, 16'd5);
    cfg_write(9, 9, 1'b1, 1'b0, 16'h0010);

    // Line 3 edge event stamped at time 50 -> deadline 150, latency 3 edges.
    push_exp(53, KPend, 0, 32'h0,   "l3_not_yet");
    push_exp(54, KPend, 0, 32'h8,   "l3_pend");
    push_exp(54, KAbs,  3, 32'd150, "l3_abs");
    push_exp(54, KTime, 0, 32'd51,  "time_54");
    applyStimulus(51, 3, 1'b1);
    applyStimulus(52, 3, 1'b0);

    // Second edge while pending -> lost, deadline kept; write clears lost.
    push_exp(62, KLost, 0, 32'h0,   "l3_lost_before");
    push_exp(63, KLost, 0, 32'h8,   "l3_lost_set");
    push_exp(63, KAbs,  3, 32'd150, "l3_abs_kept");
    push_exp(63, KPend, 0, 32'h8,   "l3_pend_kept");
    push_exp(69, KLost, 0, 32'h8,   "l3_lost_sticky");
    push_exp(70, KLost, 0, 32'h0,   "l3_lost_cleared");
    push_exp(70, KPend, 0, 32'h8,   "l3_pend_after_wr");
    applyStimulus(60, 3, 1'b1);
    applyStimulus(61, 3, 1'b0);
    cfg_write(69, 3, 1'b1, 1'b0, 16'd100);

    // Level line 5 held high: claim drops pend for exactly one cycle.
    push_exp(83, KPend, 0, 32'h28,  "l5_pend");
    push_exp(83, KAbs,  5, 32'd89,  "l5_abs");
    push_exp(90, KPend, 0, 32'h28,  "l5_pre_claim");
    push_exp(91, KPend, 0, 32'h08,  "l5_claimed");
    push_exp(91, KAbs,  5, 32'd89,  "l5_abs_on_claim");
    push_exp(92, KPend, 0, 32'h28,  "l5_repend");
    push_exp(92, KAbs,  5, 32'd98,  "l5_abs_restamp");
    applyStimulus(80, 5, 1'b1);
    claim(90, 5);
    applyStimulus(95, 5, 1'b0);

    // Line 7: claim and new edge in the same cycle -> event wins.
    push_exp(103, KPend, 0, 32'hA8,  "l7_pend");
    push_exp(103, KAbs,  7, 32'd119, "l7_abs");
    push_exp(112, KAbs,  7, 32'd119, "l7_abs_pre");
    push_exp(113, KPend, 0, 32'hA8,  "l7_claim_vs_event");
    push_exp(113, KAbs,  7, 32'd129, "l7_abs_restamp");
    push_exp(113, KLost, 0, 32'h0,   "l7_no_lost");
    push_exp(121, KPend, 0, 32'hA8,  "claim_out_of_range");
    push_exp(122, KPend, 0, 32'hA8,  "claim_oor_after");
    applyStimulus(100, 7, 1'b1);
    applyStimulus(101, 7, 1'b0);
    applyStimulus(110, 7, 1'b1);
    applyStimulus(111, 7, 1'b0);
    claim(112, 7);
    claim(120, 40);

    // Deadline wrap: event at 0xFFF8 with rel 0x10 -> 0x0008; timebase wraps.
    push_exp(65531, KPend, 0, 32'hA8,   "l9_not_yet");
    push_exp(65532, KPend, 0, 32'h2A8,  "l9_pend");
    push_exp(65532, KAbs,  9, 32'h0008, "l9_abs_wrap");
    push_exp(65538, KTime, 0, 32'hFFFF, "time_max");
    push_exp(65539, KTime, 0, 32'h0000, "time_wrap");
    applyStimulus(65529, 9, 1'b1);
    applyStimulus(65530, 9, 1'b0);

    // Disabling write drops a pending line.
    push_exp(65541, KPend, 0, 32'h228, "l7_disable_clears");
    cfg_write(65540, 7, 1'b0, 1'b0, 16'd20);

    // Lines 1 and 2 pending, line 4 mid-synchroniser, then reset.
    push_exp(65548, KPend, 0, 32'h22E, "l12_pend");
    push_exp(65548, KAbs,  1, 32'd13,  "l1_abs");
    push_exp(65551, KPend, 0, 32'h22E, "pre_reset_pend");
    push_exp(65552, KPend, 0, 32'h0,   "reset_pend");
    push_exp(65552, KLost, 0, 32'h0,   "reset_lost");
    push_exp(65552, KTime, 0, 32'h0,   "reset_time");
    push_exp(65552, KAbs,  1, 32'h0,   "reset_abs1");
    push_exp(65552, KAbs,  9, 32'h0,   "reset_abs9");
    push_exp(65553, KPend, 0, 32'h0,   "no_late_pend_a");
    push_exp(65553, KTime, 0, 32'h1,   "time_after_reset");
    push_exp(65555, KPend, 0, 32'h0,   "no_late_pend_b");
    applyStimulus(65545, 1, 1'b1);
    applyStimulus(65545, 2, 1'b1);
    applyStimulus(65546, 1, 1'b0);
    applyStimulus(65546, 2, 1'b0);
    applyStimulus(65550, 4, 1'b1);
    applyStimulus(65551, 4, 1'b0);
    at_edge(65551);
    rst_i = 1'b1;
    at_edge(65552);
    rst_i = 1'b0;

    at_edge(65558);
    @(negedge clk_i);
    #1;
    for (int i = 0; i < sb.size(); i++) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: never checked, required 0x%0h",
               sb[i].name, sb[i].val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
